// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and a funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Stores only come in signed-size flavours; loads add the unsigned ones.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between the right-aligned core data and
// the word-organised RAM: store byte enables / lane replication, load
// extraction with sign or zero extension, and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic is_byte;
    logic is_half;
    logic is_word;

    // funct3[1:0] carries the access size; funct3[2] selects zero extension.
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = (funct3[1:0] == 2'b10);

    assign misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));

    // Each lane gets its enable and the store byte that would land there.
    // Byte data is replicated to all lanes and halfword data to both halves,
    // so the enable mask alone decides what is written.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = is_byte ? (addr_lo == 2'(gi)) :
                                 is_half ? (addr_lo[1] == 1'(gi / 2)) :
                                 is_word;
            assign wdata_lanes[8*gi +: 8] = is_byte ? wdata_in[7:0] :
                                            is_half ? wdata_in[8*(gi % 2) +: 8] :
                                            wdata_in[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword out of the word and extend it.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata_word[7:0];
            2'd1:    byte_sel = rdata_word[15:8];
            2'd2:    byte_sel = rdata_word[23:16];
            default: byte_sel = rdata_word[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

        if (is_byte) begin
            rdata_ext = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            rdata_ext = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end else begin
            rdata_ext = rdata_word;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Accepts one request in IDLE, waits WAIT_CYCLES, then answers with a
// single-cycle response; stores commit on the response edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;
    logic        mem_we;
    logic        accept;

    assign accept = req_valid && req_ready_q;

    dmem_lane_align u_align (
        .funct3      (f3_q),
        .addr_lo     (addr_q[1:0]),
        .wdata_in    (wdata_q),
        .rdata_word  (rd_word_q),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    assign out_of_range = ({2'b00, addr_q[31:2]} >= DEPTH_L);
    assign acc_err      = !f3_legal(we_q, f3_q) || misalign || out_of_range;
    assign mem_we       = (state_q == ST_RESP) && we_q && !acc_err;

    // Next-state, request latching and response formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d        = req_we;
                    f3_d        = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || we_q) ? 32'd0 : rdata_ext;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // FSM and registered outputs; reset drops any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Read the addressed word at acceptance; nothing can write it before the
    // response, so the registered copy is valid even with zero wait states.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= mem[req_addr[AW+1:2]];
        end
    end

    // Byte-lane store commit on the response edge; RAM ignores reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states for
// the functional vectors, a second with zero wait states for throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid2;
    logic        req_valid0;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy2, vld2, err2;
    logic [31:0] rd2;
    logic        rdy0, vld0, err0;
    logic [31:0] rd0;

    int n_vec = 0;
    int n_bad = 0;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid2),
        .req_ready  (rdy2),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (vld2),
        .rsp_rdata  (rd2),
        .rsp_err    (err2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid0),
        .req_ready  (rdy0),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (vld0),
        .rsp_rdata  (rd0),
        .rsp_err    (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request to the two-wait-state instance; checks latency and result.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid2 = 1'b1;
        for (int k = 0; k < 20 && !rdy2; k++) @(negedge clk);
        check({tag, "_rdy"}, {31'd0, rdy2}, 32'd1);
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (vld2) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rd2, exp_rd);
        check({tag, "_err"}, {31'd0, err2}, {31'd0, exp_err});
        $display("xact %-8s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, we, f3, addr, wdata, rd2, err2, lat);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid2 = 1'b0;
        req_valid0 = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdy",   {31'd0, rdy2}, 32'd1);
        check("rst_vld",   {31'd0, vld2}, 32'd0);
        check("rst_rdata", rd2,           32'd0);
        check("rst_err",   {31'd0, err2}, 32'd0);
        check("rst_rdy0",  {31'd0, rdy0}, 32'd1);
        $display("reset released: ready=%0d valid=%0d", rdy2, vld2);

        // Word round trip, then sub-word merge and extension
        xact("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        xact("sb11",  1'b1, 3'b000, 32'h11, 32'h55667780, 32'h0,        1'b0);
        xact("sh12",  1'b1, 3'b001, 32'h12, 32'hAAAA1234, 32'h0,        1'b0);
        xact("lw10m", 1'b0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 1'b0);
        xact("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0);
        xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0);
        xact("lh12",  1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0);
        xact("lh10",  1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFF80EF, 1'b0);
        xact("lhu10", 1'b0, 3'b101, 32'h10, 32'h0,        32'h000080EF, 1'b0);
        xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'h00000012, 1'b0);

        // Faults: misaligned, out of range, illegal funct3
        xact("lw13e", 1'b0, 3'b010, 32'h13,  32'h0,        32'h0, 1'b1);
        xact("sh11e", 1'b1, 3'b001, 32'h11,  32'hFFFFFFFF, 32'h0, 1'b1);
        xact("sw100", 1'b1, 3'b010, 32'h100, 32'h11111111, 32'h0, 1'b1);
        xact("ld011", 1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 1'b1);
        xact("st100", 1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0, 1'b1);
        xact("lw10u", 1'b0, 3'b010, 32'h10,  32'h0,        32'h123480EF, 1'b0);

        // Last word of the array is still in range
        xact("swFC",  1'b1, 3'b010, 32'hFC, 32'hA5A51234, 32'h0,        1'b0);
        xact("lwFC",  1'b0, 3'b010, 32'hFC, 32'h0,        32'hA5A51234, 1'b0);

        // Reset during WAIT discards the store
        xact("pre20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0,        1'b0);
        xact("lw10r", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123480EF, 1'b0);
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h55AA55AA;
        req_valid2 = 1'b1;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        check("mid_busy", {31'd0, rdy2}, 32'd0);
        seen = 0;
        @(posedge clk);
        #1 seen = seen | int'(vld2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rdy",   {31'd0, rdy2}, 32'd1);
        check("mid_vld",   {31'd0, vld2}, 32'd0);
        check("mid_rdata", rd2,           32'd0);
        check("mid_err",   {31'd0, err2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 seen = seen | int'(vld2);
        end
        check("mid_norsp", 32'(seen), 32'd0);
        $display("reset during WAIT: responses seen=%0d", seen);
        xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

        // Zero wait states: back-to-back sw then lw on the second instance
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h04;
        req_wdata  = 32'hCAFEF00D;
        req_valid0 = 1'b1;
        check("z_rdy_a", {31'd0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        check("z_resp_rdy", {31'd0, rdy0}, 32'd0);
        check("z_resp_vld", {31'd0, vld0}, 32'd0);
        @(negedge clk);
        req_we    = 1'b0;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        check("z_sw_vld", {31'd0, vld0}, 32'd1);
        check("z_sw_err", {31'd0, err0}, 32'd0);
        check("z_rdy_b",  {31'd0, rdy0}, 32'd1);
        $display("zero-wait sw 04 CAFEF00D: valid=%0d err=%0d", vld0, err0);
        @(posedge clk);
        #1;
        check("z_lw_busy", {31'd0, rdy0}, 32'd0);
        check("z_lw_wait", {31'd0, vld0}, 32'd0);
        req_valid0 = 1'b0;
        @(posedge clk);
        #1;
        check("z_lw_vld",   {31'd0, vld0}, 32'd1);
        check("z_lw_rdata", rd0,           32'hCAFEF00D);
        $display("zero-wait lw 04: valid=%0d rdata=%h", vld0, rd0);
        @(posedge clk);
        #1;
        check("z_pulse", {31'd0, vld0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory port. It accepts load/store requests from the RISC-V core over a valid/ready handshake, serves them from an internal word-organised RAM after a programmable number of wait states, and returns one response per request. It replaces the zero-latency data memory in the top level so the core can be exercised against a multi-cycle memory. It supports byte, halfword and word accesses with RISC-V load sign/zero extension.

## Interface
- DEPTH_WORDS, default 64: number of 32-bit words; valid byte addresses are 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, default 2: wait states between acceptance and response; legal range 0 to 15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 access size and extension.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (sb uses bits 7:0, sh uses bits 15:0).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  access fault, qualified by rsp_valid.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, latch we, funct3, addr and wdata. Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT: the counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle. Move to RESP when the counter reaches 0.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. The response has no backpressure.
- Legal load funct3 values: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal store funct3 values: 000 sb, 001 sh, 010 sw. Any other value sets rsp_err.
- Misaligned accesses set rsp_err:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- Out-of-range accesses set rsp_err: addr[31:2] ≥ DEPTH_WORDS.
- On error: no RAM write, and rsp_rdata=0.
- Stores: only the addressed byte lanes are written. sb writes one lane selected by addr[1:0]. sh writes two lanes selected by addr[1]. sw writes all four lanes.
- Loads: the byte or halfword is selected by address, shifted to bits 0 upward, then extended:
  - lb and lh sign-extend;
  - lbu and lhu zero-extend.
- RAM contents are not cleared by rst and are preserved across reset.

## Timing
- Acceptance: rising edge at which req_valid && req_ready.
- Response latency: rsp_valid is high during the cycle that begins 1+WAIT_CYCLES edges after the acceptance edge.
- A store commits to RAM on the same edge at which rsp_valid rises. A load issued after that response observes the new data.
- Throughput: one request per 2+WAIT_CYCLES cycles. req_ready is low from the acceptance edge until the edge after RESP.
- Requests presented while req_ready=0 are ignored. The initiator holds them until acceptance.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset asserted during WAIT discards the pending request: no RAM write and no response.
- rsp_rdata and rsp_err are registered. They hold their last values while rsp_valid=0, except that rst clears them.

## Structure
- Package dmem_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum type dmem_state_t.
- Sub-module dmem_lane_align is purely combinational. From funct3, addr[1:0] and the data it produces:
  - the store byte-enable mask (4 bits) and the lane-shifted write data;
  - the load extraction and extension result;
  - a misalign flag.
- The top dmem_responder contains the FSM, the wait counter, the request latches and the RAM array.

## Test plan
- Aligned word round trip, WAIT_CYCLES=2: sw 0xDEADBEEF to 0x10, then lw from 0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, and each rsp_valid arrives exactly 3 cycles after its acceptance edge.
- Byte and halfword merge with extension: after the word above, sb 0x80 to 0x11 and sh 0x1234 to 0x12. Required results:
  - lw 0x10 returns 0x12348 0EF;
  - lb 0x11 returns 0xFFFFFF80;
  - lbu 0x11 returns 0x00000080;
  - lh 0x12 returns 0x00001234.
- Faults: each of the following returns rsp_err=1 and rsp_rdata=0, and word 0x10 is unchanged afterwards:
  - lw at 0x13;
  - sh at 0x11;
  - sw at 0x100 with DEPTH_WORDS=64;
  - funct3=011 load.
- Zero wait states, WAIT_CYCLES=0: back-to-back requests are accepted every 2 cycles, rsp_valid arrives 1 cycle after acceptance, and req_ready=0 in the RESP cycle.
- Reset mid-operation: sw 0x55AA55AA to 0x20, then pulse rst during WAIT. Required: no rsp_valid, outputs at reset values, and a subsequent lw 0x20 returns the prior contents (0 when preloaded with 0).
